// File: rtl/node_tx_port.sv
// node_tx_port: packet injector for one router link.
// Turns a packet request plus a stream of payload words into HEAD/BODY/TAIL
// (or HEAD_TAIL) flits. It picks one VC per packet round-robin, honours the
// downstream per-VC on/off flow control, and never interleaves packets.

package noc_params;
    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

module node_tx_port #(
    parameter  int MAX_PKT_FLITS = 16,
    localparam int SIZE_W        = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     pkt_valid_i,
    output logic                                     pkt_ready_o,
    input  logic [noc_params::DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
    input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
    input  logic [noc_params::HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic [SIZE_W-1:0]                        pkt_size_i,
    input  logic                                     pl_valid_i,
    output logic                                     pl_ready_o,
    input  logic [noc_params::FLIT_DATA_SIZE-1:0]    pl_data_i,
    input  logic [noc_params::VC_NUM-1:0]            on_off_i,
    output noc_params::flit_t                        data_o,
    output logic                                     valid_flit_o,
    output logic                                     busy_o,
    output logic                                     pkt_done_o
);
    localparam int VC_NUM  = noc_params::VC_NUM;
    localparam int VC_SIZE = noc_params::VC_SIZE;
    localparam int XW      = noc_params::DEST_ADDR_SIZE_X;
    localparam int YW      = noc_params::DEST_ADDR_SIZE_Y;
    localparam int HW      = noc_params::HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

    state_t             state, state_nxt;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic [HW-1:0]      hpl_q;
    logic [SIZE_W-1:0]  size_q;
    logic [SIZE_W-1:0]  remaining;
    logic [VC_SIZE-1:0] cur_vc;
    logic [VC_SIZE-1:0] rr_ptr;

    logic [SIZE_W-1:0]  size_eff;
    logic               sel_found;
    logic [VC_SIZE-1:0] sel_vc;
    logic [VC_SIZE-1:0] scan_idx;
    logic [VC_SIZE-1:0] rr_nxt;
    logic               accept;
    logic               head_fire;
    logic               pl_fire;
    logic               pl_go;
    logic               emit;
    logic               done_nxt;
    noc_params::flit_t  flit_nxt;

    assign busy_o = (state != IDLE);

    // Requested length normalised: 0 means a single flit, oversize clamps.
    always_comb begin
        size_eff = pkt_size_i;
        if (pkt_size_i == '0)
            size_eff = SIZE_W'(1);
        else if (pkt_size_i > SIZE_W'(MAX_PKT_FLITS))
            size_eff = SIZE_W'(MAX_PKT_FLITS);
    end

    // Round-robin VC pick: first enabled VC at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        scan_idx  = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            scan_idx = VC_SIZE'((int'(rr_ptr) + i) % VC_NUM);
            if (!sel_found && on_off_i[scan_idx]) begin
                sel_found = 1'b1;
                sel_vc    = scan_idx;
            end
        end
        rr_nxt = VC_SIZE'((int'(sel_vc) + 1) % VC_NUM);
    end

    // Next state, handshakes and the flit to be registered on this edge.
    always_comb begin
        state_nxt   = state;
        pkt_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        pl_go       = 1'b0;
        accept      = 1'b0;
        head_fire   = 1'b0;
        pl_fire     = 1'b0;
        emit        = 1'b0;
        done_nxt    = 1'b0;
        flit_nxt    = '0;
        case (state)
            IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = HEAD;
                end
            end
            HEAD: begin
                if (sel_found) begin
                    head_fire                       = 1'b1;
                    emit                            = 1'b1;
                    flit_nxt.vc_id                  = sel_vc;
                    flit_nxt.data.head_data.x_dest  = x_q;
                    flit_nxt.data.head_data.y_dest  = y_q;
                    flit_nxt.data.head_data.head_pl = hpl_q;
                    if (size_q == SIZE_W'(1)) begin
                        flit_nxt.flit_label = noc_params::HEAD_TAIL;
                        done_nxt            = 1'b1;
                        state_nxt           = IDLE;
                    end else begin
                        flit_nxt.flit_label = noc_params::HEAD;
                        state_nxt           = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // Only the packet's own VC matters once it is underway.
                pl_go      = on_off_i[cur_vc];
                pl_ready_o = pl_go;
                if (pl_go && pl_valid_i) begin
                    pl_fire            = 1'b1;
                    emit               = 1'b1;
                    flit_nxt.vc_id     = cur_vc;
                    flit_nxt.data.bt_pl = pl_data_i;
                    if (remaining == SIZE_W'(1)) begin
                        flit_nxt.flit_label = noc_params::TAIL;
                        done_nxt            = 1'b1;
                        state_nxt           = IDLE;
                    end else begin
                        flit_nxt.flit_label = noc_params::BODY;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request capture, VC bookkeeping, flit counter and registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            hpl_q        <= '0;
            size_q       <= '0;
            remaining    <= '0;
            cur_vc       <= '0;
            rr_ptr       <= '0;
            data_o       <= '0;
            valid_flit_o <= 1'b0;
            pkt_done_o   <= 1'b0;
        end else begin
            valid_flit_o <= emit;
            pkt_done_o   <= done_nxt;
            if (emit)
                data_o <= flit_nxt;
            if (accept) begin
                x_q    <= pkt_x_dest_i;
                y_q    <= pkt_y_dest_i;
                hpl_q  <= pkt_head_pl_i;
                size_q <= size_eff;
            end
            if (head_fire) begin
                cur_vc    <= sel_vc;
                rr_ptr    <= rr_nxt;
                remaining <= size_q - SIZE_W'(1);
            end else if (pl_fire) begin
                remaining <= remaining - SIZE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_node_tx_port.sv
// Bench for node_tx_port: directed test-plan steps followed by randomized
// packets, all checked against a packet-level reference model.
module tb_node_tx_port;
    localparam int MAXF   = 16;
    localparam int SW     = $clog2(MAXF + 1);
    localparam int VN     = noc_params::VC_NUM;
    localparam int XW     = noc_params::DEST_ADDR_SIZE_X;
    localparam int YW     = noc_params::DEST_ADDR_SIZE_Y;
    localparam int HW     = noc_params::HEAD_PAYLOAD_SIZE;
    localparam int DW     = noc_params::FLIT_DATA_SIZE;
    localparam int BUDGET = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid_i;
    logic              pkt_ready_o;
    logic [XW-1:0]     pkt_x_dest_i;
    logic [YW-1:0]     pkt_y_dest_i;
    logic [HW-1:0]     pkt_head_pl_i;
    logic [SW-1:0]     pkt_size_i;
    logic              pl_valid_i;
    logic              pl_ready_o;
    logic [DW-1:0]     pl_data_i;
    logic [VN-1:0]     on_off_i;
    noc_params::flit_t data_o;
    logic              valid_flit_o;
    logic              busy_o;
    logic              pkt_done_o;

    node_tx_port #(.MAX_PKT_FLITS(MAXF)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
        .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i),
        .pkt_head_pl_i(pkt_head_pl_i), .pkt_size_i(pkt_size_i),
        .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
        .on_off_i(on_off_i), .data_o(data_o), .valid_flit_o(valid_flit_o),
        .busy_o(busy_o), .pkt_done_o(pkt_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        noc_params::flit_t f;
        logic [VN-1:0]     oo;
        logic              done;
        int                cyc;
    } rec_t;

    rec_t          obs[$];
    rec_t          mon_r;
    logic [VN-1:0] mon_oo;
    int            cyc_n   = 0;
    int            total   = 0;
    int            bad     = 0;
    bit            rand_oo = 1'b0;
    int            m_rr    = 0;
    int            acc_cyc = 0;
    int            last_vc = 0;
    int            cur_eff = 0;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [HW-1:0] cur_hpl;
    logic [DW-1:0] sent_words[$];

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    // Flit log: on_off seen at each edge plus the flit it produced.
    always @(posedge clk) begin
        cyc_n++;
        mon_oo = on_off_i;
        #1;
        if (pkt_done_o) chk("done_has_flit", valid_flit_o, 1);
        if (valid_flit_o) begin
            mon_r.f    = data_o;
            mon_r.oo   = mon_oo;
            mon_r.done = pkt_done_o;
            mon_r.cyc  = cyc_n;
            obs.push_back(mon_r);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_oo)
            on_off_i = ($urandom_range(0, 2) != 0) ? '1 : VN'($urandom);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pkt_valid_i = 1'b0; pl_valid_i = 1'b0; on_off_i = '1;
        step(); step();
        chk("rst.valid", valid_flit_o, 0);
        chk("rst.done", pkt_done_o, 0);
        chk("rst.data", data_o, 0);
        chk("rst.busy", busy_o, 0);
        chk("rst.pkt_ready", pkt_ready_o, 1);
        rst = 1'b0;
        m_rr = 0;
    endtask

    task automatic fill_words();
        sent_words.delete();
        for (int i = 0; i < MAXF; i++) sent_words.push_back(DW'($urandom));
    endtask

    // Offer one packet and its payload words; returns once pkt_done is seen.
    task automatic send_pkt(input logic [XW-1:0] x, input logic [YW-1:0] y,
                            input logic [HW-1:0] hpl, input int size,
                            input int gap, input bit rgap, input int stall_vc);
        int n;
        int g;
        cur_eff = (size == 0) ? 1 : (size > MAXF) ? MAXF : size;
        cur_x = x; cur_y = y; cur_hpl = hpl;
        obs.delete();
        pkt_x_dest_i = x; pkt_y_dest_i = y; pkt_head_pl_i = hpl;
        pkt_size_i = SW'(size); pkt_valid_i = 1'b1;
        n = 0;
        while (!pkt_ready_o && n < BUDGET) begin step(); n++; end
        chk("accept_wait", n < BUDGET, 1);
        acc_cyc = cyc_n + 1;
        step();
        pkt_valid_i = 1'b0;
        chk("busy_blocks_req", pkt_ready_o, 0);
        for (int k = 0; k < cur_eff - 1; k++) begin
            g = rgap ? $urandom_range(0, gap) : gap;
            if (k > 0) repeat (g) begin pl_valid_i = 1'b0; step(); end
            pl_valid_i = 1'b1;
            pl_data_i  = sent_words[k];
            if (k == 1 && stall_vc >= 0) begin
                on_off_i = ~(VN'(1) << stall_vc);
                #1;
                repeat (3) begin
                    chk("stall.pl_ready", pl_ready_o, 0);
                    step();
                    chk("stall.no_flit", valid_flit_o, 0);
                end
                on_off_i = '1;
                #1;
            end
            n = 0;
            while (!pl_ready_o && n < BUDGET) begin step(); n++; end
            chk("pl_wait", n < BUDGET, 1);
            step();
        end
        pl_valid_i = 1'b0;
        n = 0;
        while (!pkt_done_o && n < BUDGET) begin step(); n++; end
        chk("done_wait", n < BUDGET, 1);
    endtask

    // Compare the logged flits of one packet with what the packet rules predict.
    task automatic check_pkt(input string tag);
        int ev;
        int v;
        ev = -1;
        chk({tag, ".count"}, obs.size(), cur_eff);
        if (obs.size() > 0) begin
            for (int i = 0; i < VN; i++) begin
                v = (m_rr + i) % VN;
                if (ev < 0 && obs[0].oo[v]) ev = v;
            end
            chk({tag, ".head_lbl"}, obs[0].f.flit_label,
                (cur_eff == 1) ? noc_params::HEAD_TAIL : noc_params::HEAD);
            chk({tag, ".head_vc"}, obs[0].f.vc_id, ev);
            chk({tag, ".head_data"}, obs[0].f.data.head_data, {cur_x, cur_y, cur_hpl});
            chk({tag, ".head_done"}, obs[0].done, cur_eff == 1);
            if (ev >= 0) m_rr = (ev + 1) % VN;
        end
        for (int k = 1; k < obs.size() && k < cur_eff; k++) begin
            chk({tag, ".lbl"}, obs[k].f.flit_label,
                (k == cur_eff - 1) ? noc_params::TAIL : noc_params::BODY);
            chk({tag, ".pl"}, obs[k].f.data.bt_pl, sent_words[k-1]);
            chk({tag, ".vc"}, obs[k].f.vc_id, ev);
            chk({tag, ".perm"}, (ev >= 0) ? obs[k].oo[ev] : 1'b0, 1);
            chk({tag, ".done"}, obs[k].done, k == cur_eff - 1);
        end
        last_vc = ev;
    endtask

    initial begin
        int t_prev;
        int sz;
        pkt_x_dest_i = '0; pkt_y_dest_i = '0; pkt_head_pl_i = '0; pkt_size_i = '0;
        pl_data_i = '0;
        do_reset();

        // Size 4 to (1,2), words A,B,C back to back.
        sent_words = '{16'hA, 16'hB, 16'hC};
        send_pkt(2'd1, 2'd2, 12'h5A5, 4, 0, 1'b0, -1);
        check_pkt("t1");
        chk("t1.vc0", last_vc, 0);
        if (obs.size() == 4) begin
            chk("t1.head_latency", obs[0].cyc, acc_cyc + 1);
            for (int k = 1; k < 4; k++) chk("t1.back2back", obs[k].cyc - obs[k-1].cyc, 1);
        end
        fill_words();
        send_pkt(2'd3, 2'd0, 12'h111, 1, 0, 1'b0, -1);
        check_pkt("t1b");
        if (obs.size() > 0) chk("t1b.rr_advanced", obs[0].f.vc_id, 1);

        // Size 1 then size 2 from reset: vc0 then vc1 with one idle link cycle.
        do_reset();
        fill_words();
        send_pkt(2'd0, 2'd1, 12'h0F0, 1, 0, 1'b0, -1);
        check_pkt("t2a");
        if (obs.size() > 0) chk("t2a.vc", obs[0].f.vc_id, 0);
        t_prev = (obs.size() > 0) ? obs[obs.size()-1].cyc : 0;
        send_pkt(2'd2, 2'd3, 12'h0E1, 2, 0, 1'b0, -1);
        check_pkt("t2b");
        if (obs.size() > 0) begin
            chk("t2b.vc", obs[0].f.vc_id, 1);
            chk("t2b.idle_gap", obs[0].cyc - t_prev, 2);
        end

        // VC0 off at HEAD: packet goes to vc1 and stays there.
        do_reset();
        on_off_i = VN'(4'b1110);
        fill_words();
        send_pkt(2'd1, 2'd1, 12'h333, 3, 0, 1'b0, -1);
        check_pkt("t3");
        if (obs.size() > 0) chk("t3.vc", obs[obs.size()-1].f.vc_id, 1);
        on_off_i = '1;

        // Size 5 with its VC dropped for 3 cycles after the first BODY.
        do_reset();
        fill_words();
        send_pkt(2'd2, 2'd2, 12'h444, 5, 0, 1'b0, 0);
        check_pkt("t4");

        // Two-cycle gaps between payload words.
        fill_words();
        send_pkt(2'd3, 2'd3, 12'h555, 4, 2, 1'b0, -1);
        check_pkt("t5");
        for (int k = 2; k < obs.size(); k++) chk("t5.gap", obs[k].cyc - obs[k-1].cyc, 3);

        // Reset right after the HEAD of a size-6 packet, with a word on offer.
        do_reset();
        obs.delete();
        pkt_x_dest_i = 2'd1; pkt_y_dest_i = 2'd0; pkt_head_pl_i = 12'h666;
        pkt_size_i = SW'(6); pkt_valid_i = 1'b1;
        step();
        pkt_valid_i = 1'b0;
        pl_valid_i = 1'b1; pl_data_i = 16'hBEEF;
        step();
        chk("t6.head_seen", obs.size(), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pl_valid_i = 1'b0;
        chk("t6.valid", valid_flit_o, 0);
        chk("t6.busy", busy_o, 0);
        chk("t6.pkt_ready", pkt_ready_o, 1);
        m_rr = 0;
        fill_words();
        send_pkt(2'd0, 2'd3, 12'h777, 2, 0, 1'b0, -1);
        check_pkt("t6b");
        if (obs.size() > 0) chk("t6b.vc", obs[0].f.vc_id, 0);

        // Randomized packets, random gaps and random per-VC flow control.
        rand_oo = 1'b1;
        for (int p = 0; p < 30; p++) begin
            sz = (p == 0) ? 0 : (p == 1) ? 20 : $urandom_range(0, 20);
            fill_words();
            send_pkt(XW'($urandom), YW'($urandom), HW'($urandom), sz, 2, 1'b1, -1);
            check_pkt("rnd");
        end
        rand_oo = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
